// File: rtl/ram_dp_sr_sw_be.sv
// Simple dual-port synchronous RAM (one write port, one read port, one clock)
// with per-byte write enables, 1- or 2-cycle read latency, selectable
// read-during-write policy and an optional zero-fill sequence after reset.
//
// Ports:
//   clk       - clock, all logic on rising edge
//   rst_n     - synchronous active-low reset
//   wr_en     - write request
//   wr_addr   - write address
//   wr_data   - write data
//   wr_be     - byte enables, bit i covers wr_data[i*BYTE_WIDTH +: BYTE_WIDTH]
//   rd_en     - read request
//   rd_addr   - read address
//   rd_data   - read data, holds its last value while rd_valid is low
//   rd_valid  - rd_data carries a read issued READ_LATENCY cycles earlier
//   init_done - array ready; requests are ignored while low
module ram_dp_sr_sw_be #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_NEW        = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wr_be,
  input  logic                               rd_en,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  output logic                               init_done
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;

  // Reject parameter sets the datapath cannot honour.
  if ((DATA_WIDTH % BYTE_WIDTH) != 0 || (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_bad_params
    $fatal(1, "ram_dp_sr_sw_be: illegal DATA_WIDTH/BYTE_WIDTH or READ_LATENCY");
  end

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic                    mem_we_c;
  logic [ADDR_WIDTH-1:0]   mem_addr_c;
  logic [DATA_WIDTH-1:0]   mem_wdata_c;
  logic [NUM_BYTES-1:0]    mem_be_c;
  logic                    ready_c;
  logic                    rd_fire_c;
  logic [DATA_WIDTH-1:0]   rd_word_c;
  logic                    pipe_valid_c;
  logic [DATA_WIDTH-1:0]   pipe_data_c;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign ready_c   = (state_q == ST_READY);
  assign rd_fire_c = rst_n && ready_c && rd_en;

  // FSM next state and shared write-port mux (fill engine vs user port).
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    mem_we_c    = 1'b0;
    mem_addr_c  = wr_addr;
    mem_wdata_c = wr_data;
    mem_be_c    = wr_be;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_addr_c  = clr_cnt_q;
        mem_wdata_c = '0;
        mem_be_c    = '1;
        clr_cnt_d   = ADDR_WIDTH'(clr_cnt_q + 1'b1);
        if (clr_cnt_q == '1) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      ST_READY: begin
        mem_we_c = wr_en && (wr_be != '0);
      end
      default: state_d = ST_READY;
    endcase
    // A write sampled together with reset must not land in the array.
    if (!rst_n) mem_we_c = 1'b0;
  end

  // Array write with byte lanes; no reset on the storage itself.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (mem_be_c[i]) mem[mem_addr_c][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata_c[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Word seen by a read at its issue edge, optionally forwarding same-address write bytes.
  always_comb begin
    rd_word_c = mem[rd_addr];
    if (RDW_NEW != 0 && ready_c && mem_we_c && (wr_addr == rd_addr)) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) rd_word_c[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

    // Extra stage captures the issue-edge word so later writes cannot disturb it.
    always_comb begin
      s1_valid_d = rd_fire_c;
      s1_data_d  = rd_fire_c ? rd_word_c : s1_data_q;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
      end
    end

    assign pipe_valid_c = s1_valid_q;
    assign pipe_data_c  = s1_data_q;
  end else begin : g_lat1
    assign pipe_valid_c = rd_fire_c;
    assign pipe_data_c  = rd_word_c;
  end

  // Output stage: data only moves when a result arrives.
  always_comb begin
    rd_valid_d = pipe_valid_c;
    rd_data_d  = pipe_valid_c ? pipe_data_c : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q   <= '0;
      init_done_q <= (CLEAR_ON_RESET == 0);
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_dp_sr_sw_be.sv
// Directed bench for ram_dp_sr_sw_be: one instance with default parameters
// (latency 1, new-data RDW) and one with latency 2 and old-data RDW, both
// driven by the same stimulus.
module tb_ram_dp_sr_sw_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [63:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2;
  logic        init_done1, init_done2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_dp_sr_sw_be u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .init_done(init_done1)
  );

  ram_dp_sr_sw_be #(.READ_LATENCY(2), .RDW_NEW(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .init_done(init_done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_be = 8'h00; rd_en = 1'b0;
  endtask

  task automatic write(input logic [11:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    idle();
  endtask

  task automatic wait_init(input string tag);
    int  n;
    bit  saw_valid;
    n = 0;
    saw_valid = 1'b0;
    while (!init_done1 && n < 5000) begin
      tick();
      n++;
      if (rd_valid1 || rd_valid2) saw_valid = 1'b1;
    end
    chk({tag, "_fill_cycles"}, 64'(n), 64'd4096);
    chk({tag, "_no_valid_in_clear"}, 64'(saw_valid), 64'd0);
    chk({tag, "_init_done2"}, 64'(init_done2), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    idle();

    // 1: reset state, fill with requests pending, all-zero readback
    tick(); tick();
    chk("rst_valid1", 64'(rd_valid1), 64'd0);
    chk("rst_data1",  rd_data1, 64'd0);
    chk("rst_init1",  64'(init_done1), 64'd0);
    chk("rst_valid2", 64'(rd_valid2), 64'd0);
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 12'h005; wr_data = 64'hDEAD_BEEF_0000_1234; wr_be = 8'hFF;
    rd_en = 1'b1; rd_addr = 12'h005;
    wait_init("clr1");
    idle();

    rd_en = 1'b1; rd_addr = 12'h000; tick();
    chk("z0_v1", 64'(rd_valid1), 64'd1);
    chk("z0_d1", rd_data1, 64'd0);
    chk("z0_v2_early", 64'(rd_valid2), 64'd0);
    rd_addr = 12'h018; tick();
    chk("z0_v2", 64'(rd_valid2), 64'd1);
    chk("z18_d1", rd_data1, 64'd0);
    rd_addr = 12'hFFF; tick();
    chk("zfff_d1", rd_data1, 64'd0);
    rd_addr = 12'h005; tick();
    chk("z5_d1", rd_data1, 64'd0);
    idle(); tick();
    chk("z5_d2", rd_data2, 64'd0);
    chk("z_idle_v1", 64'(rd_valid1), 64'd0);

    // 2: write then back-to-back reads
    write(12'h000, 64'h0000_0000_0000_00A5, 8'hFF);
    write(12'h018, 64'h0000_0000_0000_1234, 8'hFF);
    rd_en = 1'b1; rd_addr = 12'h018; tick();
    chk("b2b_a_d1", rd_data1, 64'h1234);
    chk("b2b_a_v1", 64'(rd_valid1), 64'd1);
    rd_addr = 12'h000; tick();
    chk("b2b_b_d1", rd_data1, 64'hA5);
    chk("b2b_b_v1", 64'(rd_valid1), 64'd1);
    chk("b2b_a_d2", rd_data2, 64'h1234);
    chk("b2b_a_v2", 64'(rd_valid2), 64'd1);
    idle(); tick();
    chk("b2b_hold_v1", 64'(rd_valid1), 64'd0);
    chk("b2b_hold_d1", rd_data1, 64'hA5);
    chk("b2b_b_d2", rd_data2, 64'hA5);
    chk("b2b_b_v2", 64'(rd_valid2), 64'd1);
    tick();
    chk("b2b_idle_v2", 64'(rd_valid2), 64'd0);
    chk("b2b_hold_d2", rd_data2, 64'hA5);

    // 3: byte enables
    write(12'h101, 64'h0123_4567_89AB_CDEF, 8'hFF);
    write(12'h101, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    write(12'h101, 64'h5555_AAAA_5555_AAAA, 8'h00);
    rd_en = 1'b1; rd_addr = 12'h101; tick();
    idle();
    chk("be_d1", rd_data1, 64'h0123_4567_FFFF_FFFF);
    tick();
    chk("be_d2", rd_data2, 64'h0123_4567_FFFF_FFFF);

    // 4: read-during-write, same and different addresses
    write(12'h019, 64'h1111, 8'hFF);
    wr_en = 1'b1; wr_addr = 12'h019; wr_data = 64'h2222; wr_be = 8'hFF;
    rd_en = 1'b1; rd_addr = 12'h019; tick();
    chk("rdw_new_d1", rd_data1, 64'h2222);
    wr_addr = 12'h030; wr_data = 64'h7; rd_addr = 12'h018; tick();
    chk("rdw_old_d2", rd_data2, 64'h1111);
    chk("indep_d1", rd_data1, 64'h1234);
    wr_en = 1'b0; wr_be = 8'h00; rd_addr = 12'h019; tick();
    chk("rdw_after_d1", rd_data1, 64'h2222);
    chk("indep_d2", rd_data2, 64'h1234);
    rd_addr = 12'h030; tick();
    chk("rdw_after_d2", rd_data2, 64'h2222);
    chk("indep_wr_d1", rd_data1, 64'h7);
    idle(); tick();

    // 5: write after issue does not disturb an in-flight latency-2 read
    write(12'h020, 64'h5, 8'hFF);
    rd_en = 1'b1; rd_addr = 12'h020; tick();
    chk("infl_d1", rd_data1, 64'h5);
    rd_en = 1'b0; wr_en = 1'b1; wr_addr = 12'h020; wr_data = 64'h6; wr_be = 8'hFF; tick();
    idle();
    chk("infl_d2", rd_data2, 64'h5);
    chk("infl_v2", 64'(rd_valid2), 64'd1);
    rd_en = 1'b1; rd_addr = 12'h020; tick();
    idle();
    chk("later_d1", rd_data1, 64'h6);
    tick();
    chk("later_d2", rd_data2, 64'h6);
    tick();
    chk("drop_v2", 64'(rd_valid2), 64'd0);
    chk("drop_hold_d2", rd_data2, 64'h6);
    chk("drop_hold_d1", rd_data1, 64'h6);

    // 6: reset in READY with a read active, then reset mid-fill
    write(12'hFFF, 64'hCAFE_F00D_0000_0001, 8'hFF);
    rd_en = 1'b1; rd_addr = 12'h020; rst_n = 1'b0; tick();
    chk("rr_v1", 64'(rd_valid1), 64'd0);
    chk("rr_d1", rd_data1, 64'd0);
    chk("rr_d2", rd_data2, 64'd0);
    chk("rr_init1", 64'(init_done1), 64'd0);
    idle(); rst_n = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_init1", 64'(init_done1), 64'd0);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    wait_init("clr2");
    idle();
    rd_en = 1'b1; rd_addr = 12'h018; tick();
    chk("post_018_d1", rd_data1, 64'd0);
    rd_addr = 12'h101; tick();
    chk("post_101_d1", rd_data1, 64'd0);
    chk("post_018_d2", rd_data2, 64'd0);
    rd_addr = 12'hFFF; tick();
    chk("post_fff_d1", rd_data1, 64'd0);
    chk("post_101_d2", rd_data2, 64'd0);
    rd_addr = 12'h020; tick();
    chk("post_020_d1", rd_data1, 64'd0);
    chk("post_fff_d2", rd_data2, 64'd0);
    idle(); tick();
    chk("post_020_d2", rd_data2, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
